// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch unit: the FSM state encoding and the {pc, instr}
// entry carried by the fetch FIFO.
package fetch_unit_pkg;

  localparam int unsigned FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_END   = 2'd1,
    ST_ERR   = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of fetched {pc, instr} pairs. Flush wins over push/pop;
// a push into a full FIFO is accepted only when a pop frees a slot that cycle.
module fetch_fifo
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [FIFO_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'(FIFO_DEPTH)) || do_pop);

  // NOTE: the storage is reset too, because the head entry feeds the decode
  // outputs directly and those must read zero while reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC register, FETCH/END/ERR state machine and
// redirect handling, feeding decode through a two-entry fetch FIFO.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_o,
  input  logic [31:0] instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_pc_o,
  output logic [31:0] out_instr_o,
  output logic        misalign_o,
  output logic        end_o
);

  localparam logic [31:0] LAST_WORD = 32'(IMEM_BYTES - 4);

  fetch_state_e state;
  fetch_state_e state_next;
  fetch_entry_t head;
  logic [1:0]   count;
  logic         push;
  logic         pop;
  logic         at_last_word;
  logic         target_aligned;
  logic         target_in_range;

  // Compare in 33 bits so pc_o + 4 cannot wrap near the top of the address space.
  assign at_last_word    = ({1'b0, pc_o} + 33'd4) > {1'b0, LAST_WORD};
  assign target_aligned  = word_aligned(redirect_pc_i);
  assign target_in_range = redirect_pc_i <= LAST_WORD;

  assign out_valid_o = (count != 2'd0) && !redirect_i;
  assign pop         = out_valid_o && out_ready_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_next;
  end

  // NOTE: defaults first, so no path through this block leaves a latch.
  always_comb begin
    state_next = state;
    if (redirect_i) begin
      if (!target_aligned)       state_next = ST_ERR;
      else if (!target_in_range) state_next = ST_END;
      else                       state_next = ST_FETCH;
    end else if (push && at_last_word) begin
      state_next = ST_END;
    end
  end

  always_comb begin
    push  = (state == ST_FETCH) && !redirect_i && ((count != 2'd2) || pop);
    end_o = (state == ST_END);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_o       <= RESET_PC;
      misalign_o <= 1'b0;
    end else if (redirect_i) begin
      if (!target_aligned) begin
        pc_o       <= {redirect_pc_i[31:2], 2'b00};
        misalign_o <= 1'b1;
      end else begin
        pc_o       <= redirect_pc_i;
        misalign_o <= 1'b0;
      end
    end else if (push && !at_last_word) begin
      pc_o <= pc_o + 32'd4;
    end
  end

  fetch_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_i),
    .push       (push),
    .pop        (pop),
    .push_entry ('{pc: pc_o, instr: instr_i}),
    .head       (head),
    .count      (count)
  );

  assign out_pc_o    = head.pc;
  assign out_instr_o = head.instr;

endmodule
